// File: rtl/gci_special_pkg.sv
// Shared definitions for the GCI device special-region register file:
// controller state encoding, fixed descriptor entry indices and the
// default doorbell entry.
package gci_special_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,  // sequential clear of the array after reset
    ST_IDLE = 2'd1,  // ready to accept a request
    ST_RESP = 2'd2   // single response cycle
  } state_e;

  localparam int IDX_USEMEMSIZE = 0;
  localparam int IDX_PRIORITY   = 1;
  localparam int IDX_DEVICECAT  = 2;

  localparam logic [7:0] DOORBELL_ADDR_DEFAULT = 8'h10;

endpackage

// File: rtl/gci_special_bytemask_ram.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables and a
// registered, read-first output. No reset on the storage so it maps onto
// block RAM; the owner is responsible for initialising the contents.
module gci_special_bytemask_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [DATA_W/8-1:0]       be_i,
  input  logic [$clog2(DEPTH)-1:0]  addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write and registered read of the addressed entry.
  // NOTE: the array and its read register get no reset; a reset branch would
  // stop the tools from mapping this onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gci_device_special_regfile.sv
// GCI device special-region register file. Descriptor words (size,
// priority, category) and scratch entries, accessed by the hub through a
// request/busy handshake with a one-cycle registered response.
// Optional doorbell interrupt: define GCI_DEVICE_SPECIAL_REGFILE_DOORBELL_EN.
module gci_device_special_regfile
  import gci_special_pkg::*;
#(
  parameter int                 DEPTH         = 256,
  parameter int                 ADDR_W        = 8,
  parameter int                 DATA_W        = 32,
  parameter logic [DATA_W-1:0]  USEMEMSIZE    = '0,
  parameter logic [DATA_W-1:0]  PRIORITY      = '0,
  parameter logic [DATA_W-1:0]  DEVICECAT     = '0,
  parameter int                 RO_WORDS      = 3,
  parameter logic [ADDR_W-1:0]  DOORBELL_ADDR = ADDR_W'(DOORBELL_ADDR_DEFAULT)
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iSPECIAL_REQ,
  output logic                 oSPECIAL_BUSY,
  input  logic                 iSPECIAL_RW,
  input  logic [ADDR_W-1:0]    iSPECIAL_ADDR,
  input  logic [DATA_W/8-1:0]  iSPECIAL_MASK,
  input  logic [DATA_W-1:0]    iSPECIAL_DATA,
  output logic                 oSPECIAL_VALID,
  output logic                 oSPECIAL_ERROR,
  output logic [DATA_W-1:0]    oSPECIAL_DATA,
  output logic                 oIRQ
);

  localparam int                RAM_AW   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   RO_X     = (ADDR_W+1)'(RO_WORDS);
  localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(DEPTH - 1);

  // Reject unsupported configurations at elaboration.
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (ADDR_W < RAM_AW) begin : g_bad_addr_w
    $error("ADDR_W too small to index DEPTH entries");
  end
  if (RO_WORDS < 0 || RO_WORDS > DEPTH) begin : g_bad_ro
    $error("RO_WORDS outside 0..DEPTH");
  end
  if ({1'b0, DOORBELL_ADDR} >= DEPTH_X) begin : g_bad_doorbell
    $error("DOORBELL_ADDR outside the array");
  end

  state_e              state_q, state_d;
  logic [RAM_AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic                err_q, err_d;     // response carries ERROR
  logic                rd_ok_q, rd_ok_d; // response carries array data

  logic                accept, in_range, is_ro, wr_ok;
  logic                ram_we;
  logic [DATA_W/8-1:0] ram_be;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata, init_word;

  assign accept   = (state_q == ST_IDLE) && iSPECIAL_REQ;
  assign in_range = ({1'b0, iSPECIAL_ADDR} < DEPTH_X);
  assign is_ro    = ({1'b0, iSPECIAL_ADDR} < RO_X);
  assign wr_ok    = accept && iSPECIAL_RW && in_range && !is_ro;

  // State register plus the per-request response flags captured on acceptance.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would chain them within the cycle.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // Next state: clear every entry once, then alternate IDLE/RESP per request.
  // NOTE: each output of this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    err_d     = err_q;
    rd_ok_d   = rd_ok_q;
    unique case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (iSPECIAL_REQ) begin
          state_d = ST_RESP;
          err_d   = !in_range || (iSPECIAL_RW && is_ro);
          rd_ok_d = !iSPECIAL_RW && in_range;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Reset value of the entry currently being cleared.
  always_comb begin
    init_word = '0;
    if (clr_cnt_q == RAM_AW'(IDX_USEMEMSIZE)) init_word = USEMEMSIZE;
    if (clr_cnt_q == RAM_AW'(IDX_PRIORITY))   init_word = PRIORITY;
    if (clr_cnt_q == RAM_AW'(IDX_DEVICECAT))  init_word = DEVICECAT;
  end

  // Outputs: array port steering and the response interface.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = iSPECIAL_MASK;
    ram_addr  = iSPECIAL_ADDR[RAM_AW-1:0];
    ram_wdata = iSPECIAL_DATA;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_cnt_q;
      ram_wdata = init_word;
    end else if (wr_ok) begin
      ram_we    = 1'b1;
    end
    oSPECIAL_BUSY  = (state_q != ST_IDLE);
    oSPECIAL_VALID = (state_q == ST_RESP);
    oSPECIAL_ERROR = oSPECIAL_VALID && err_q;
    oSPECIAL_DATA  = (oSPECIAL_VALID && rd_ok_q) ? ram_rdata : '0;
  end

  gci_special_bytemask_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (iCLOCK),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

`ifdef GCI_DEVICE_SPECIAL_REGFILE_DOORBELL_EN
  logic irq_q;
  logic db_hit;

  assign db_hit = (iSPECIAL_ADDR == DOORBELL_ADDR);

  // Sticky doorbell: set by a real write to the entry, cleared by reading it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      irq_q <= 1'b0;
    end else if (wr_ok && db_hit && (|iSPECIAL_MASK)) begin
      irq_q <= 1'b1;
    end else if (accept && !iSPECIAL_RW && db_hit) begin
      irq_q <= 1'b0;
    end
  end

  assign oIRQ = irq_q;
`else
  assign oIRQ = 1'b0;
`endif

endmodule

// File: tb/tb_gci_device_special_regfile.sv
// Directed bench for gci_device_special_regfile: reset state, init clear
// length and abort, descriptor defaults, RO protection, byte masks,
// back-to-back streaming and the doorbell interrupt.
module tb_gci_device_special_regfile;

  localparam logic [31:0] USEMEM = 32'h0010_0000;
  localparam logic [31:0] PRIO   = 32'h0000_0005;
  localparam logic [31:0] DCAT   = 32'h0000_00A7;
`ifdef GCI_DEVICE_SPECIAL_REGFILE_DOORBELL_EN
  localparam logic DB_ON = 1'b1;
`else
  localparam logic DB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic        busy, valid, err, irq;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_mis = 0;

  gci_device_special_regfile #(
    .DEPTH(256), .ADDR_W(8), .DATA_W(32),
    .USEMEMSIZE(USEMEM), .PRIORITY(PRIO), .DEVICECAT(DCAT),
    .RO_WORDS(3), .DOORBELL_ADDR(8'h10)
  ) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iSPECIAL_REQ(req), .oSPECIAL_BUSY(busy), .iSPECIAL_RW(rw),
    .iSPECIAL_ADDR(addr), .iSPECIAL_MASK(mask), .iSPECIAL_DATA(wdata),
    .oSPECIAL_VALID(valid), .oSPECIAL_ERROR(err), .oSPECIAL_DATA(rdata),
    .oIRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Count clock cycles until BUSY drops, noting any VALID seen meanwhile.
  task automatic count_init(output int cycles, output int valids);
    cycles = 0;
    valids = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (valid) valids++;
    end while (busy && cycles < 2000);
  endtask

  // One request from a negedge; returns at the negedge after the response.
  task automatic do_req(input string tag, input logic w, input logic [7:0] a,
                        input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic ir);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    req = 1'b1; rw = w; addr = a; mask = m; wdata = d;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, valid}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    rd = rdata; er = err; ir = irq;
    req = 1'b0;
    @(negedge clk);
    check({tag, "_vdrop"}, {31'b0, valid}, 32'd0);
  endtask

  // Back-to-back stimulus table: REQ stays high throughout.
  logic        s_rw   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0]  s_addr [6] = '{8'd20, 8'd20, 8'd21, 8'd21, 8'd1, 8'd1};
  logic [31:0] s_data [6] = '{32'h1234_5678, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0BAD_0BAD, 32'h0};
  logic [31:0] s_exp  [6] = '{32'h0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 32'h0, PRIO};
  logic        s_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int cyc, v1, v2;
    logic [31:0] rd;
    logic er, ir;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_error", {31'b0, err}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);

    // Request raised during INIT, then reset after 100 clear cycles
    req = 1'b1; rw = 1'b0; addr = 8'd0; mask = 4'h0;
    rst_n = 1'b1;
    v1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) v1++;
    end
    check("mid_init_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd1);
    check("abort_valid", {31'b0, valid}, 32'd0);
    rst_n = 1'b1;
    count_init(cyc, v2);
    check("init_cycles", cyc, 32'd256);
    check("init_no_valid", v1 + v2, 32'd0);

    // REQ held through BUSY is taken on the first IDLE cycle
    @(posedge clk);
    @(negedge clk);
    check("held_valid", {31'b0, valid}, 32'd1);
    check("held_data", rdata, USEMEM);
    check("held_error", {31'b0, err}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    check("held_idle", {31'b0, busy}, 32'd0);

    // Descriptor defaults and scratch clear
    do_req("rd5", 1'b0, 8'd5, 4'h0, 32'h0, rd, er, ir);
    check("rd5_data", rd, 32'd0);
    check("rd5_err", {31'b0, er}, 32'd0);
    do_req("rd2", 1'b0, 8'd2, 4'h0, 32'h0, rd, er, ir);
    check("rd2_data", rd, DCAT);

    // Read-only descriptor
    do_req("wr1", 1'b1, 8'd1, 4'hF, 32'hDEAD_BEEF, rd, er, ir);
    check("wr1_err", {31'b0, er}, 32'd1);
    do_req("rd1", 1'b0, 8'd1, 4'h0, 32'h0, rd, er, ir);
    check("rd1_data", rd, PRIO);
    check("rd1_err", {31'b0, er}, 32'd0);

    // Byte masks, including the empty mask
    do_req("wr8a", 1'b1, 8'd8, 4'hF, 32'hAABB_CCDD, rd, er, ir);
    check("wr8a_err", {31'b0, er}, 32'd0);
    do_req("wr8b", 1'b1, 8'd8, 4'b0101, 32'h1122_3344, rd, er, ir);
    do_req("rd8", 1'b0, 8'd8, 4'h0, 32'h0, rd, er, ir);
    check("rd8_data", rd, 32'hAA22_CC44);
    do_req("wr8z", 1'b1, 8'd8, 4'h0, 32'hFFFF_FFFF, rd, er, ir);
    check("wr8z_err", {31'b0, er}, 32'd0);
    do_req("rd8z", 1'b0, 8'd8, 4'h0, 32'h0, rd, er, ir);
    check("rd8z_data", rd, 32'hAA22_CC44);
    check("pre_db_irq", {31'b0, ir}, 32'd0);

    // Streaming with REQ held high: one response every second cycle
    req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rw = s_rw[i]; addr = s_addr[i]; mask = 4'hF; wdata = s_data[i];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("str%0d_valid", i), {31'b0, valid}, 32'd1);
      check($sformatf("str%0d_err", i), {31'b0, err}, {31'b0, s_err[i]});
      if (!s_rw[i]) check($sformatf("str%0d_data", i), rdata, s_exp[i]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("str%0d_gap", i), {30'b0, busy, valid}, 32'd0);
    end
    req = 1'b0;

    // Doorbell
    do_req("db_wr", 1'b1, 8'h10, 4'h1, 32'h0000_0055, rd, er, ir);
    check("db_wr_irq", {31'b0, ir}, {31'b0, DB_ON});
    @(negedge clk);
    check("db_sticky", {31'b0, irq}, {31'b0, DB_ON});
    do_req("db_rd", 1'b0, 8'h10, 4'h0, 32'h0, rd, er, ir);
    check("db_rd_data", rd, 32'h0000_0055);
    check("db_rd_irq", {31'b0, ir}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
